led_pattern_sequencer: RTL

//  Sequences the board LED bank. Owns the step prescaler and the LED pattern register.
//  Two debounced push-buttons select the pattern mode and the step speed.

---
 rtl/led_seq_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/led_pattern_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
//   mode_e       : pattern mode (ROTL, ROTR, BOUNCE, COUNT)
//   dir_e        : bounce direction (LEFT, RIGHT)
//   SEED_WALK    : led value loaded when entering ROTL, ROTR or BOUNCE
//   SEED_COUNT   : led value loaded when entering COUNT
//   presc_period : step period in clk cycles for a given speed
package led_seq_pkg;

  typedef enum logic [1:0] {
    ROTL   = 2'd0,
    ROTR   = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam int unsigned SEED_WALK  = 1;
  localparam int unsigned SEED_COUNT = 0;

  function automatic int unsigned presc_period(input int unsigned base, input logic [1:0] speed);
    return base >> speed;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debouncer and press pulse.
//   clk     : system clock
//   rst_s   : asynchronous reset, active-high
//   btn_raw : raw button, active-high, asynchronous to clk
//   press   : one-cycle pulse when the debounced state goes 0->1
// The debounced state follows the synced input only after DEB_CYCLES
// consecutive disagreeing cycles; a single agreeing cycle restarts the count.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst_s,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // this is the DEB_CYCLES-th disagreeing cycle: accept the new level
        state <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer with four patterns and four step speeds.
//   clk         : system clock
//   rst_s       : asynchronous reset, active-high
//   mode_btn_i  : raw mode button (advances the pattern mode)
//   speed_btn_i : raw speed button (advances the step speed)
//   led         : pattern register, drives the pins directly
//   mode_o      : current mode
//   speed_o     : current speed, step period = PRESC_BASE >> speed_o
//   step_o      : one-cycle pulse on the cycle led advances
//
// mode   | meaning
// ROTL   | rotate one lit bit towards the MSB
// ROTR   | rotate one lit bit towards the LSB
// BOUNCE | walk one lit bit end to end, reversing at each end
// COUNT  | binary up-count, wraps at 2^LEDS_NR
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned LEDS_NR    = 6,
  parameter int unsigned PRESC_BASE = 12_000_000,
  parameter int unsigned DEB_CYCLES = 120_000
) (
  input  logic               clk,
  input  logic               rst_s,
  input  logic               mode_btn_i,
  input  logic               speed_btn_i,
  output logic [LEDS_NR-1:0] led,
  output logic [1:0]         mode_o,
  output logic [1:0]         speed_o,
  output logic               step_o
);

  localparam int unsigned PW = $clog2(PRESC_BASE);

  logic               mode_press;
  logic               speed_press;
  mode_e              mode;
  mode_e              mode_next;
  dir_e               dir;
  dir_e               dir_step;
  logic [1:0]         speed;
  logic [1:0]         speed_next;
  logic [PW-1:0]      presc;
  logic [LEDS_NR-1:0] led_step;
  logic [LEDS_NR-1:0] led_seed;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_btn (
    .clk     (clk),
    .rst_s   (rst_s),
    .btn_raw (mode_btn_i),
    .press   (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_speed_btn (
    .clk     (clk),
    .rst_s   (rst_s),
    .btn_raw (speed_btn_i),
    .press   (speed_press)
  );

  function automatic logic [PW-1:0] reload_val(input logic [1:0] spd);
    return PW'(presc_period(PRESC_BASE, spd) - 1);
  endfunction

  always_comb begin
    mode_next  = mode_e'(mode + 2'd1);
    speed_next = speed_press ? speed + 2'd1 : speed;
    led_seed   = (mode_next == COUNT) ? LEDS_NR'(SEED_COUNT) : LEDS_NR'(SEED_WALK);
  end

  always_comb begin
    led_step = led;
    dir_step = dir;
    case (mode)
      ROTL:   led_step = {led[LEDS_NR-2:0], led[LEDS_NR-1]};
      ROTR:   led_step = {led[0], led[LEDS_NR-1:1]};
      BOUNCE: begin
        // reverse on the step that would leave the end, so no end is held twice
        if (dir == LEFT) begin
          if (led[LEDS_NR-1]) begin
            dir_step = RIGHT;
            led_step = led >> 1;
          end else begin
            led_step = led << 1;
          end
        end else begin
          if (led[0]) begin
            dir_step = LEFT;
            led_step = led << 1;
          end else begin
            led_step = led >> 1;
          end
        end
      end
      COUNT:   led_step = led + LEDS_NR'(1);
      default: led_step = led;
    endcase
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      led    <= LEDS_NR'(SEED_WALK);
      mode   <= ROTL;
      speed  <= 2'd0;
      dir    <= LEFT;
      step_o <= 1'b0;
      presc  <= PW'(PRESC_BASE - 1);
    end else begin
      step_o <= 1'b0;
      if (mode_press || speed_press) begin
        // a press restarts the step period and swallows any coincident step
        presc <= reload_val(speed_next);
        speed <= speed_next;
        if (mode_press) begin
          mode <= mode_next;
          dir  <= LEFT;
          led  <= led_seed;
        end
      end else if (presc == '0) begin
        presc  <= reload_val(speed);
        led    <= led_step;
        dir    <= dir_step;
        step_o <= 1'b1;
      end else begin
        presc <= presc - PW'(1);
      end
    end
  end

  assign mode_o  = mode;
  assign speed_o = speed;

endmodule
